// File: rtl/tdm_demux_if.sv
// tdm_demux_if: beat input and per-channel output bundle of the TDM demultiplexer.
interface tdm_demux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  logic                in_valid;
  logic                in_sync;
  logic [W-1:0]        in_data;
  logic [N_CH*W-1:0]   out_data;
  logic [N_CH-1:0]     out_valid;
  logic                frame_done;
  logic                sync_err;
  logic                locked;
  modport master (
    output in_valid, in_sync, in_data,
    input  out_data, out_valid, frame_done, sync_err, locked
  );
  modport slave (
    input  in_valid, in_sync, in_data,
    output out_data, out_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: locks onto frame-start beats and steers each slot into its channel register.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input logic        clk,
  input logic        rst,
  tdm_demux_if.slave bus
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n, slot;
  logic                    wr, err;
  logic [N_CH-1:0][W-1:0]  data_q;
  logic [N_CH-1:0]         valid_q;
  logic                    done_q, err_q;
  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] c);
    return c == LAST ? '0 : c + 1'b1;
  endfunction
  // A sync beat is always slot 0; a non-sync beat at slot 0 means the frame was lost.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr      = 1'b0;
    slot    = cnt;
    err     = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sync) begin
        wr      = 1'b1;
        slot    = '0;
        err     = state == LOCKED && cnt != '0;
        state_n = LOCKED;
      end else if (state == LOCKED) begin
        wr      = cnt != '0;
        err     = cnt == '0;
        state_n = cnt == '0 ? HUNT : LOCKED;
      end
      cnt_n = wr ? nxt(slot) : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      valid_q <= wr ? N_CH'(1) << slot : '0;
      done_q  <= wr && slot == LAST;
      err_q   <= err;
      if (wr) data_q[slot] <= bus.in_data;
    end
  end
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.sync_err   = err_q;
  assign bus.locked     = state == LOCKED;
endmodule
